mux_32_1_rr_arbiter: RTL and testbench
======================================

# mux_32_1_rr_arbiter

Round-robin arbiter that shares the 32:1 MUX among 32 single-bit requesters. It grants one requester at a time, drives the MUX select and enable, and holds each grant until the owner signals done, drops its request, or hits a hold-time limit. It sits directly in front of `MUX_32_1`: `Select_Out` drives `Select_In` and `Enable_Out` drives `Enable_In`.

## Interface
- `MAX_HOLD`, default 16: maximum consecutive cycles a grant may be held (legal range 1..255).
- `Clock_In`  in  1  single clock, rising edge.
- `Reset_In`  in  1  asynchronous, active-high reset.
- `Request_In`  in  32  bit i = requester i wants the MUX.
- `Done_In`  in  1  the current owner releases the grant; sampled only in GRANT.
- `Grant_Out`  out  32  one-hot grant; all zero when not in GRANT.
- `Select_Out`  out  5  index of the current or last granted requester; to MUX `Select_In`.
- `Enable_Out`  out  1  high exactly while in GRANT; to MUX `Enable_In`.
- `Timeout_Out`  out  1  one-cycle pulse when a grant is force-released by `MAX_HOLD`.

## Operation
- All outputs are registered.
- Reset values:
  - `Grant_Out` = 0, `Select_Out` = 0, `Enable_Out` = 0, `Timeout_Out` = 0.
  - State = IDLE, last-grant pointer = 31, hold counter = 0.
- FSM has two states, IDLE and GRANT.
- IDLE:
  - If `Request_In` != 0, pick the winner and go to GRANT on that edge.
  - Otherwise stay in IDLE; `Select_Out` keeps its last value.
- Winner selection:
  - Search the first set bit starting at (pointer+1) mod 32 and ascending with wrap-around; the pointer index itself is checked last.
  - On a grant, load the winner index into `Select_Out` and the pointer, set `Grant_Out` = 1<<winner, set `Enable_Out` = 1, and set the hold counter to 1.
- GRANT: release at the edge where any of the following holds.
  - (a) `Done_In` = 1.
  - (b) `Request_In[Select_Out]` = 0.
  - (c) Hold counter = `MAX_HOLD`. Release (c) also sets `Timeout_Out` = 1 for the next cycle, unless (a) or (b) is true on the same edge; (a)/(b) take precedence and give no timeout pulse.
  - If no release condition holds, increment the hold counter; it saturates at `MAX_HOLD`.
- Release action: go to IDLE, clear `Grant_Out` and `Enable_Out`, and keep `Select_Out`.
  - Every grant is followed by at least one IDLE cycle with `Enable_Out` = 0.
  - There is no direct GRANT-to-GRANT transition.
- Fairness:
  - After requester k is served, every other pending requester is served before k again.
  - With all 32 requesting, the grant order is k+1, k+2, …, wrapping.
- Requests arriving or changing during GRANT for non-owners have no effect until the next IDLE cycle.
- Hold counter width is 8 bits.

## Timing
- Request to grant:
  - A request sampled high in IDLE at edge t gives `Grant_Out`/`Enable_Out` high after edge t.
  - Latency is 1 cycle from IDLE.
- Grant duration:
  - A release condition sampled at edge t drops `Enable_Out` after edge t.
  - A grant with `Done_In` asserted on the first GRANT cycle lasts exactly 1 cycle.
  - The maximum grant length is `MAX_HOLD` cycles.
- Back-to-back service: the minimum period per grant is 2 cycles (1 GRANT + 1 IDLE).
- `Timeout_Out` is high for exactly one cycle, coincident with the first IDLE cycle after a forced release.
- Reset mid-grant:
  - Asserting `Reset_In` clears all outputs immediately, without waiting for a clock edge.
  - Ownership is lost, and the pointer returns to 31, so requester 0 has top priority after reset.
- `Select_Out` changes only on a grant edge, so the MUX data path is stable for the whole grant.

## Test plan
- Reset priority:
  - Stimulus: reset; then `Request_In` = 32'hFFFF_FFFF held, `Done_In` pulsed on each GRANT cycle.
  - Response: grants go to 0, 1, 2, …, 31, 0; `Enable_Out` toggles 1,0,1,0; `Select_Out` matches each index.
- Wrap and skip:
  - Stimulus: pointer = 30; `Request_In` = bits {3, 30}.
  - Response: the next grant is 3 (wrap past 31 and 0); the following grant is 30.
- Timeout, with `MAX_HOLD` = 4:
  - Stimulus: requester 7 holds its request with `Done_In` = 0.
  - Response: `Enable_Out` high for exactly 4 cycles; `Timeout_Out` pulses once; after one idle cycle requester 7 is re-granted if it is alone.
- Request drop and precedence:
  - Stimulus: requester 5 is granted and drops `Request_In[5]` on the second cycle.
  - Response: release after that edge with no timeout.
  - Stimulus: `Done_In` and the timeout occur on the same edge.
  - Response: `Timeout_Out` stays 0.
- Async reset mid-grant:
  - Stimulus: assert `Reset_In` between clock edges while granting 12.
  - Response: `Grant_Out`, `Enable_Out` and `Select_Out` go to 0 immediately; after release, requests {0, 12} give a grant to 0 first.
- MUX integration:
  - Stimulus: connect to `MUX_32_1`; drive data inputs with random values; use random requests for 200 cycles.
  - Response:
    - `MUX_Data_Out` equals Data_i whenever `Grant_Out[i]` = 1, and 0 when `Enable_Out` = 0.
    - `Grant_Out` is never more than one-hot.
    - There is no starvation: every continuously requesting index is granted within 32 grants.

Source files
------------

// File: rtl/mux_32_1_rr_arbiter.sv
// Round-robin arbiter sharing a 32:1 MUX among 32 single-bit requesters.
// One owner at a time; the grant is held until the owner signals done,
// drops its request, or has held the MUX for MAX_HOLD cycles.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | no owner; a pending request is granted on the next edge
// ST_GRANT | one requester owns the MUX; hold counter runs
module mux_32_1_rr_arbiter #(
   parameter int MAX_HOLD = 16
) (
   input  logic        Clock_In,
   input  logic        Reset_In,
   input  logic [31:0] Request_In,
   input  logic        Done_In,
   output logic [31:0] Grant_Out,
   output logic [4:0]  Select_Out,
   output logic        Enable_Out,
   output logic        Timeout_Out
);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_t;

   state_t      state_q, state_d;
   logic [4:0]  ptr_q, ptr_d;
   logic [7:0]  hold_q, hold_d;
   logic [31:0] grant_q, grant_d;
   logic [4:0]  sel_q, sel_d;
   logic        en_q, en_d;
   logic        to_q, to_d;

   logic [4:0]  win_idx;
   logic        win_found;
   logic        rel_owner;
   logic        rel_limit;

   // Rotating priority search: first set bit after the pointer, pointer itself last.
   always_comb begin
      logic [4:0] idx;
      win_idx   = '0;
      win_found = 1'b0;
      idx       = '0;
      for (int i = 1; i <= 32; i++) begin
         idx = ptr_q + 5'(i);
         if (!win_found && Request_In[idx]) begin
            win_idx   = idx;
            win_found = 1'b1;
         end
      end
   end

   // Owner-driven release (done or dropped request) outranks the hold limit.
   always_comb begin
      rel_owner = Done_In | ~Request_In[sel_q];
      rel_limit = (hold_q == 8'(MAX_HOLD));
   end

   // Next-state and registered-output decode.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      hold_d  = hold_q;
      grant_d = grant_q;
      sel_d   = sel_q;
      en_d    = en_q;
      to_d    = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (win_found) begin
               state_d = ST_GRANT;
               ptr_d   = win_idx;
               sel_d   = win_idx;
               grant_d = 32'h1 << win_idx;
               en_d    = 1'b1;
               hold_d  = 8'd1;
            end
         end
         ST_GRANT: begin
            if (rel_owner || rel_limit) begin
               state_d = ST_IDLE;
               grant_d = '0;
               en_d    = 1'b0;
               to_d    = rel_limit & ~rel_owner;
            end else if (!rel_limit) begin
               hold_d = hold_q + 8'd1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            grant_d = '0;
            en_d    = 1'b0;
         end
      endcase
   end

   // State and output registers; reset leaves requester 0 at top priority.
   always_ff @(posedge Clock_In or posedge Reset_In) begin
      if (Reset_In) begin
         state_q <= ST_IDLE;
         ptr_q   <= 5'd31;
         hold_q  <= '0;
         grant_q <= '0;
         sel_q   <= '0;
         en_q    <= 1'b0;
         to_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         hold_q  <= hold_d;
         grant_q <= grant_d;
         sel_q   <= sel_d;
         en_q    <= en_d;
         to_q    <= to_d;
      end
   end

   assign Grant_Out   = grant_q;
   assign Select_Out  = sel_q;
   assign Enable_Out  = en_q;
   assign Timeout_Out = to_q;

endmodule

// File: tb/tb_mux_32_1_rr_arbiter.sv
// Bench for the round-robin MUX arbiter, built with MAX_HOLD = 4.
module tb_mux_32_1_rr_arbiter;

   localparam int MAX_HOLD = 4;

   logic        clk;
   logic        rst;
   logic [31:0] req_v;
   logic        done_v;
   logic [31:0] Grant_Out;
   logic [4:0]  Select_Out;
   logic        Enable_Out;
   logic        Timeout_Out;

   logic [31:0] data_v [32];
   logic [31:0] mux_out;

   int n_checks;
   int n_errors;

   // Reference model: owner index or -1 when idle.
   int m_owner;
   int m_ptr;
   int m_sel;
   int m_hold;
   bit m_to;

   mux_32_1_rr_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
      .Clock_In   (clk),
      .Reset_In   (rst),
      .Request_In (req_v),
      .Done_In    (done_v),
      .Grant_Out  (Grant_Out),
      .Select_Out (Select_Out),
      .Enable_Out (Enable_Out),
      .Timeout_Out(Timeout_Out)
   );

   // Behavioural stand-in for MUX_32_1 driven by the arbiter outputs.
   assign mux_out = Enable_Out ? data_v[Select_Out] : 32'h0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic model_reset();
      m_owner = -1;
      m_ptr   = 31;
      m_sel   = 0;
      m_hold  = 0;
      m_to    = 1'b0;
   endtask

   task automatic model_edge();
      m_to = 1'b0;
      if (m_owner < 0) begin
         if (req_v != 32'h0) begin
            for (int i = 1; i <= 32; i++) begin
               int c;
               c = (m_ptr + i) % 32;
               if (req_v[c]) begin
                  m_owner = c;
                  m_ptr   = c;
                  m_sel   = c;
                  m_hold  = 1;
                  break;
               end
            end
         end
      end else begin
         if (done_v || !req_v[m_owner]) begin
            m_owner = -1;
         end else if (m_hold == MAX_HOLD) begin
            m_owner = -1;
            m_to    = 1'b1;
         end else begin
            m_hold++;
         end
      end
   endtask

   function automatic logic [31:0] exp_grant();
      return (m_owner < 0) ? 32'h0 : (32'h1 << m_owner);
   endfunction

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      model_reset();
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      req_v  = '0;
      done_v = 1'b0;
      rst    = 1'b1;
      #2;
      n_checks++;
      if (Grant_Out !== 32'h0) begin n_errors++; $display("FAIL reset_grant got=%h exp=0", Grant_Out); end
      n_checks++;
      if (Select_Out !== 5'd0) begin n_errors++; $display("FAIL reset_sel got=%0d exp=0", Select_Out); end
      n_checks++;
      if (Enable_Out !== 1'b0) begin n_errors++; $display("FAIL reset_en got=%b exp=0", Enable_Out); end
      n_checks++;
      if (Timeout_Out !== 1'b0) begin n_errors++; $display("FAIL reset_to got=%b exp=0", Timeout_Out); end
      model_reset();
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset_priority();
      int order[$];
      do_reset();
      req_v  = 32'hFFFF_FFFF;
      done_v = 1'b1;
      for (int c = 0; c < 66; c++) begin
         tick();
         n_checks++;
         if (Grant_Out !== exp_grant()) begin n_errors++; $display("FAIL prio_grant cyc=%0d got=%h exp=%h", c, Grant_Out, exp_grant()); end
         n_checks++;
         if (Enable_Out !== (c % 2 == 0)) begin n_errors++; $display("FAIL prio_en cyc=%0d got=%b exp=%b", c, Enable_Out, (c % 2 == 0)); end
         if (Enable_Out) order.push_back(int'(Select_Out));
      end
      n_checks++;
      if (order.size() != 33) begin n_errors++; $display("FAIL prio_count got=%0d exp=33", order.size()); end
      for (int i = 0; i < order.size() && i < 33; i++) begin
         n_checks++;
         if (order[i] != i % 32) begin n_errors++; $display("FAIL prio_order idx=%0d got=%0d exp=%0d", i, order[i], i % 32); end
      end
   endtask

   task automatic test_wrap_skip();
      do_reset();
      req_v  = 32'h1 << 30;
      done_v = 1'b0;
      tick();
      n_checks++;
      if (Select_Out !== 5'd30 || Enable_Out !== 1'b1) begin n_errors++; $display("FAIL wrap_setup sel=%0d en=%b exp sel=30 en=1", Select_Out, Enable_Out); end
      done_v = 1'b1;
      tick();
      req_v = (32'h1 << 3) | (32'h1 << 30);
      tick();
      n_checks++;
      if (Grant_Out !== (32'h1 << 3) || Select_Out !== 5'd3) begin n_errors++; $display("FAIL wrap_first grant=%h sel=%0d exp grant=%h sel=3", Grant_Out, Select_Out, 32'h1 << 3); end
      tick();
      n_checks++;
      if (Enable_Out !== 1'b0 || Select_Out !== 5'd3) begin n_errors++; $display("FAIL wrap_idle en=%b sel=%0d exp en=0 sel=3", Enable_Out, Select_Out); end
      tick();
      n_checks++;
      if (Grant_Out !== (32'h1 << 30) || Select_Out !== 5'd30) begin n_errors++; $display("FAIL wrap_second grant=%h sel=%0d exp grant=%h sel=30", Grant_Out, Select_Out, 32'h1 << 30); end
   endtask

   task automatic test_timeout();
      bit en_h[8];
      bit to_h[8];
      int to_cnt;
      do_reset();
      req_v  = 32'h1 << 7;
      done_v = 1'b0;
      to_cnt = 0;
      for (int c = 0; c < 8; c++) begin
         tick();
         en_h[c] = Enable_Out;
         to_h[c] = Timeout_Out;
         n_checks++;
         if (Timeout_Out !== m_to || Grant_Out !== exp_grant()) begin n_errors++; $display("FAIL tmo_model cyc=%0d to=%b grant=%h exp to=%b grant=%h", c, Timeout_Out, Grant_Out, m_to, exp_grant()); end
      end
      for (int c = 0; c < 4; c++) begin
         n_checks++;
         if (en_h[c] !== 1'b1) begin n_errors++; $display("FAIL tmo_hold cyc=%0d en=%b exp=1", c, en_h[c]); end
      end
      for (int c = 0; c < 6; c++) to_cnt += int'(to_h[c]);
      n_checks++;
      if (en_h[4] !== 1'b0 || to_h[4] !== 1'b1) begin n_errors++; $display("FAIL tmo_release en=%b to=%b exp en=0 to=1", en_h[4], to_h[4]); end
      n_checks++;
      if (to_cnt != 1) begin n_errors++; $display("FAIL tmo_pulses got=%0d exp=1", to_cnt); end
      n_checks++;
      if (en_h[5] !== 1'b1) begin n_errors++; $display("FAIL tmo_regrant en=%b exp=1", en_h[5]); end
   endtask

   task automatic test_drop_precedence();
      do_reset();
      req_v  = 32'h1 << 5;
      done_v = 1'b0;
      tick();
      tick();
      n_checks++;
      if (Enable_Out !== 1'b1 || Select_Out !== 5'd5) begin n_errors++; $display("FAIL drop_setup en=%b sel=%0d exp en=1 sel=5", Enable_Out, Select_Out); end
      req_v = 32'h0;
      tick();
      n_checks++;
      if (Enable_Out !== 1'b0 || Grant_Out !== 32'h0 || Timeout_Out !== 1'b0) begin n_errors++; $display("FAIL drop_release en=%b grant=%h to=%b exp 0/0/0", Enable_Out, Grant_Out, Timeout_Out); end
      n_checks++;
      if (Select_Out !== 5'd5) begin n_errors++; $display("FAIL drop_keepsel got=%0d exp=5", Select_Out); end
      req_v = 32'h1 << 9;
      for (int c = 0; c < MAX_HOLD; c++) tick();
      n_checks++;
      if (Enable_Out !== 1'b1 || Select_Out !== 5'd9) begin n_errors++; $display("FAIL prec_setup en=%b sel=%0d exp en=1 sel=9", Enable_Out, Select_Out); end
      done_v = 1'b1;
      tick();
      n_checks++;
      if (Enable_Out !== 1'b0 || Timeout_Out !== 1'b0) begin n_errors++; $display("FAIL prec_to en=%b to=%b exp en=0 to=0", Enable_Out, Timeout_Out); end
      done_v = 1'b0;
      req_v  = 32'h0;
      tick();
      n_checks++;
      if (Timeout_Out !== 1'b0) begin n_errors++; $display("FAIL prec_to_late got=%b exp=0", Timeout_Out); end
   endtask

   task automatic test_async_reset();
      bit got0;
      do_reset();
      req_v  = 32'h1 << 12;
      done_v = 1'b0;
      tick();
      n_checks++;
      if (Select_Out !== 5'd12 || Enable_Out !== 1'b1) begin n_errors++; $display("FAIL arst_setup sel=%0d en=%b exp sel=12 en=1", Select_Out, Enable_Out); end
      #2;
      rst = 1'b1;
      #1;
      n_checks++;
      if (Grant_Out !== 32'h0 || Enable_Out !== 1'b0 || Select_Out !== 5'd0) begin n_errors++; $display("FAIL arst_clear grant=%h en=%b sel=%0d exp all 0", Grant_Out, Enable_Out, Select_Out); end
      model_reset();
      @(negedge clk);
      rst   = 1'b0;
      req_v = (32'h1 << 0) | (32'h1 << 12);
      got0  = 1'b0;
      for (int c = 0; c < 4 && !got0; c++) begin
         tick();
         if (Enable_Out) begin
            got0 = 1'b1;
            n_checks++;
            if (Select_Out !== 5'd0) begin n_errors++; $display("FAIL arst_prio got=%0d exp=0", Select_Out); end
         end
      end
      if (!got0) begin n_checks++; n_errors++; $display("FAIL arst_timeout got=no_grant exp=grant"); end
   endtask

   task automatic test_random_mux();
      logic [31:0] sticky;
      int wait_cnt[32];
      int worst;
      bit prev_en;
      do_reset();
      sticky = (32'h1 << $urandom_range(0, 7)) | (32'h1 << $urandom_range(8, 15)) |
               (32'h1 << $urandom_range(16, 23)) | (32'h1 << $urandom_range(24, 31));
      for (int i = 0; i < 32; i++) wait_cnt[i] = 0;
      worst   = 0;
      prev_en = 1'b0;
      for (int c = 0; c < 200; c++) begin
         req_v  = ($urandom & $urandom & $urandom) | sticky;
         done_v = ($urandom_range(0, 3) == 0);
         for (int i = 0; i < 32; i++) data_v[i] = $urandom;
         tick();
         n_checks++;
         if (Grant_Out !== exp_grant() || Enable_Out !== (m_owner >= 0) || Select_Out !== 5'(m_sel) || Timeout_Out !== m_to) begin
            n_errors++;
            $display("FAIL rnd_model cyc=%0d grant=%h en=%b sel=%0d to=%b exp grant=%h en=%b sel=%0d to=%b",
                     c, Grant_Out, Enable_Out, Select_Out, Timeout_Out, exp_grant(), (m_owner >= 0), m_sel, m_to);
         end
         n_checks++;
         if ($countones(Grant_Out) > 1) begin n_errors++; $display("FAIL rnd_onehot cyc=%0d got=%h exp<=1hot", c, Grant_Out); end
         n_checks++;
         if (mux_out !== ((m_owner >= 0) ? data_v[m_owner] : 32'h0)) begin
            n_errors++;
            $display("FAIL rnd_mux cyc=%0d got=%h exp=%h", c, mux_out, (m_owner >= 0) ? data_v[m_owner] : 32'h0);
         end
         if (Enable_Out && !prev_en) begin
            for (int i = 0; i < 32; i++) begin
               if (sticky[i]) begin
                  if (Select_Out == 5'(i)) wait_cnt[i] = 0;
                  else wait_cnt[i]++;
                  if (wait_cnt[i] > worst) worst = wait_cnt[i];
               end
            end
         end
         prev_en = Enable_Out;
      end
      n_checks++;
      if (worst > 32) begin n_errors++; $display("FAIL rnd_starve got=%0d exp<=32", worst); end
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst      = 1'b0;
      req_v    = '0;
      done_v   = 1'b0;
      for (int i = 0; i < 32; i++) data_v[i] = '0;
      model_reset();
      test_reset();
      test_reset_priority();
      test_wrap_skip();
      test_timeout();
      test_drop_precedence();
      test_async_reset();
      test_random_mux();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
